core_seq: RTL

Multi-cycle instruction sequencer for the RV32 core. It owns the PC and instruction register and steps each instruction through fetch, decode, execute, memory and writeback. It drives the instruction and data memory request/acknowledge handshakes and evaluates branch and jump outcomes. It sits between the memories and the combinational control decoder/ALU, which receive `ir` fields and the enables produced here.

---
 rtl/core_pkg.sv | 75 +++++++
 rtl/core_seq_if.sv | 29 ++
 rtl/core_seq_req_timer.sv | 36 +++
 rtl/core_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared types, opcode constants and decode helpers for core_seq
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } seq_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        TC_ILLEGAL      = 2'd0,
        TC_MISALIGN     = 2'd1,
        TC_IMEM_TIMEOUT = 2'd2,
        TC_DMEM_TIMEOUT = 2'd3
    } trap_cause_t;

    typedef enum logic [2:0] {
        CL_R       = 3'd0,
        CL_I       = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_JAL     = 3'd5,
        CL_ILLEGAL = 3'd6
    } instr_class_t;

    function automatic instr_class_t classify(input logic [6:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_R:      cls = CL_R;
            OP_I:      cls = CL_I;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Unsigned variants (110/111) rely on the ALU having produced an unsigned lt.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = lt;
            3'b111:  taken = !lt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_seq_if.sv
// ============================================================================
// core_seq_if : instruction/data memory request-acknowledge handshakes
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface core_seq_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

`default_nettype wire

// File: rtl/core_seq_req_timer.sv
// ============================================================================
// req_timer : 8-bit memory wait counter, shared by fetch and data accesses
// Revision  : 1.0
// ============================================================================
`default_nettype none

module req_timer #(
    parameter int TIMEOUT = 255
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  clear,
    input  wire  enable,
    output logic expired
);
    // The counter holds the number of completed wait cycles, so it reaches
    // LIMIT during the TIMEOUT-th consecutive request cycle.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = (r_count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/core_seq.sv
// ============================================================================
// core_seq : multi-cycle RV32 sequencer owning PC/IR and memory handshakes
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_seq
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             halt,
    core_seq_if.master      mem,
    output logic [31:0]     ir,
    input  wire  [XLEN-1:0] imm,
    input  wire             alu_zero,
    input  wire             alu_lt,
    output logic            alu_en,
    output logic            rf_we,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    seq_state_t      r_state;
    seq_state_t      w_state_next;
    logic            r_fetch_pend;
    logic [XLEN-1:0] r_jal_target;

    instr_class_t    w_class;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_target_misaligned;
    logic            w_fetch_active;
    logic            w_mem_active;
    logic            w_req_any;
    logic            w_ack_any;
    logic            w_timer_clear;
    logic            w_expired;

    logic            w_pc_load;
    logic [XLEN-1:0] w_pc_next;
    logic            w_ir_load;
    logic            w_jal_load;
    logic            w_trap_set;
    trap_cause_t     w_cause;

    assign w_class             = classify(ir[6:0]);
    assign w_f3                = ir[14:12];
    assign w_pc_plus4          = pc + XLEN'(4);
    assign w_target            = pc + imm;
    assign w_target_misaligned = |w_target[1:0];

    // Halt only suppresses a new fetch; an issued request is held to completion.
    assign w_fetch_active = (r_state == S_FETCH) && (r_fetch_pend || !halt);
    assign w_mem_active   = (r_state == S_MEM);
    assign w_req_any      = w_fetch_active || w_mem_active;
    assign w_ack_any      = (w_fetch_active && mem.imem_ack) ||
                            (w_mem_active && mem.dmem_ack);
    assign w_timer_clear  = !w_req_any || w_ack_any;

    // rst gating makes the fetch request fall immediately on reset assertion.
    assign mem.imem_req  = rst && w_fetch_active;
    assign mem.imem_addr = pc;
    assign mem.dmem_req  = w_mem_active;
    assign mem.dmem_we   = w_mem_active && (w_class == CL_STORE);

    req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_req_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (w_req_any),
        .expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_next    = w_pc_plus4;
        w_ir_load    = 1'b0;
        w_jal_load   = 1'b0;
        w_trap_set   = 1'b0;
        w_cause      = TC_ILLEGAL;

        case (r_state)
            S_FETCH: begin
                if (w_fetch_active) begin
                    // An ack in the limit cycle takes priority over the timeout.
                    if (mem.imem_ack) begin
                        w_ir_load    = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_expired) begin
                        w_trap_set = 1'b1;
                        w_cause    = TC_IMEM_TIMEOUT;
                    end
                end
            end

            S_DECODE: begin
                if ((w_class == CL_ILLEGAL) ||
                    ((w_class == CL_BRANCH) && (w_f3[2:1] == 2'b01))) begin
                    w_trap_set = 1'b1;
                    w_cause    = TC_ILLEGAL;
                end else begin
                    w_state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_en = 1'b1;
                case (w_class)
                    CL_R, CL_I:        w_state_next = S_WB;
                    CL_LOAD, CL_STORE: w_state_next = S_MEM;
                    CL_BRANCH: begin
                        if (branch_taken(w_f3, alu_zero, alu_lt)) begin
                            if (w_target_misaligned) begin
                                w_trap_set = 1'b1;
                                w_cause    = TC_MISALIGN;
                            end else begin
                                w_pc_load    = 1'b1;
                                w_pc_next    = w_target;
                                retire       = 1'b1;
                                w_state_next = S_FETCH;
                            end
                        end else begin
                            w_pc_load    = 1'b1;
                            retire       = 1'b1;
                            w_state_next = S_FETCH;
                        end
                    end
                    CL_JAL: begin
                        if (w_target_misaligned) begin
                            w_trap_set = 1'b1;
                            w_cause    = TC_MISALIGN;
                        end else begin
                            w_jal_load   = 1'b1;
                            w_state_next = S_WB;
                        end
                    end
                    default: begin
                        w_trap_set = 1'b1;
                        w_cause    = TC_ILLEGAL;
                    end
                endcase
            end

            S_MEM: begin
                if (mem.dmem_ack) begin
                    if (w_class == CL_STORE) begin
                        w_pc_load    = 1'b1;
                        retire       = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_trap_set = 1'b1;
                    w_cause    = TC_DMEM_TIMEOUT;
                end
            end

            S_WB: begin
                rf_we        = 1'b1;
                retire       = 1'b1;
                w_pc_load    = 1'b1;
                w_pc_next    = (w_class == CL_JAL) ? r_jal_target : w_pc_plus4;
                w_state_next = S_FETCH;
            end

            S_TRAP: begin
                w_state_next = S_TRAP;
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        if (w_trap_set) begin
            w_state_next = S_TRAP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            pc           <= RESET_PC;
            ir           <= 32'd0;
            trap         <= 1'b0;
            trap_cause   <= 2'd0;
            r_fetch_pend <= 1'b0;
            r_jal_target <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pend <= w_fetch_active && !mem.imem_ack && !w_expired;
            if (w_pc_load) begin
                pc <= w_pc_next;
            end
            if (w_ir_load) begin
                ir <= mem.imem_rdata;
            end
            if (w_jal_load) begin
                r_jal_target <= w_target;
            end
            if (w_trap_set) begin
                trap       <= 1'b1;
                trap_cause <= w_cause;
            end
        end
    end

endmodule

`default_nettype wire
